// File: rtl/arbiter_types_pkg.sv
// Shared types and widths for the pmem arbiter slice.
package arbiter_types_pkg;
    localparam int LINE_W   = 256;
    localparam int ADDR_W   = 32;
    localparam int OFFSET_W = 5;

    typedef enum logic [1:0] {IDLE, GRANT_I, GRANT_D, RELEASE} arb_state_t;
    typedef enum logic {CLIENT_I, CLIENT_D} client_t;
endpackage

// File: rtl/pmem_arbiter_rr.sv
// Two-way round-robin pick. Purely combinational; the caller owns last_grant.
module rr_arbiter2
    import arbiter_types_pkg::*;
(
    input  logic    req_i,
    input  logic    req_d,
    input  client_t last_grant,
    output logic    gnt_valid,
    output client_t pick
);
    // On a tie the client that did not win last time goes next.
    always_comb begin
        gnt_valid = req_i | req_d;
        pick      = CLIENT_I;
        if (req_i && req_d)
            pick = (last_grant == CLIENT_I) ? CLIENT_D : CLIENT_I;
        else if (req_d)
            pick = CLIENT_D;
    end
endmodule

// File: rtl/pmem_arbiter.sv
// Merges I-cache and D-cache line requests onto one physical-memory port.
// Address and write data are captured at grant and held until pmem_resp.
module pmem_arbiter #(
    parameter int LINE_W   = arbiter_types_pkg::LINE_W,
    parameter int ADDR_W   = arbiter_types_pkg::ADDR_W,
    parameter int OFFSET_W = arbiter_types_pkg::OFFSET_W
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              i_read,
    input  logic [ADDR_W-1:0] i_addr,
    output logic [LINE_W-1:0] i_rdata,
    output logic              i_resp,
    input  logic              d_read,
    input  logic              d_write,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [LINE_W-1:0] d_wdata,
    output logic [LINE_W-1:0] d_rdata,
    output logic              d_resp,
    output logic              pmem_read,
    output logic              pmem_write,
    output logic [ADDR_W-1:0] pmem_addr,
    output logic [LINE_W-1:0] pmem_wdata,
    input  logic [LINE_W-1:0] pmem_rdata,
    input  logic              pmem_resp
);
    import arbiter_types_pkg::*;

    localparam logic [ADDR_W-1:0] ADDR_MASK = {{(ADDR_W-OFFSET_W){1'b1}}, {OFFSET_W{1'b0}}};

    arb_state_t        state_q, state_d;
    client_t           last_grant_q;
    client_t           pick;
    logic              gnt_valid;
    logic              grant;
    logic [ADDR_W-1:0] addr_q;
    logic [LINE_W-1:0] wdata_q;
    logic              op_wr_q;

    rr_arbiter2 u_rr (
        .req_i      (i_read),
        .req_d      (d_read | d_write),
        .last_grant (last_grant_q),
        .gnt_valid  (gnt_valid),
        .pick       (pick)
    );

    // State and transaction capture; d_write wins over d_read when both are set.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= IDLE;
            last_grant_q <= CLIENT_I;
            addr_q       <= '0;
            wdata_q      <= '0;
            op_wr_q      <= 1'b0;
        end else begin
            state_q <= state_d;
            if (grant) begin
                addr_q       <= ((pick == CLIENT_D) ? d_addr : i_addr) & ADDR_MASK;
                wdata_q      <= d_wdata;
                op_wr_q      <= (pick == CLIENT_D) && d_write;
                last_grant_q <= pick;
            end
        end
    end

    // Next state plus Moore pmem outputs; resp/rdata pass through in the resp cycle.
    always_comb begin
        state_d    = state_q;
        grant      = 1'b0;
        pmem_read  = 1'b0;
        pmem_write = 1'b0;
        pmem_addr  = '0;
        pmem_wdata = '0;
        i_resp     = 1'b0;
        d_resp     = 1'b0;
        i_rdata    = '0;
        d_rdata    = '0;
        case (state_q)
            IDLE: begin
                if (gnt_valid) begin
                    grant   = 1'b1;
                    state_d = (pick == CLIENT_D) ? GRANT_D : GRANT_I;
                end
            end
            GRANT_I: begin
                pmem_read  = 1'b1;
                pmem_addr  = addr_q;
                pmem_wdata = wdata_q;
                if (pmem_resp) begin
                    i_resp  = 1'b1;
                    i_rdata = pmem_rdata;
                    state_d = RELEASE;
                end
            end
            GRANT_D: begin
                pmem_read  = ~op_wr_q;
                pmem_write = op_wr_q;
                pmem_addr  = addr_q;
                pmem_wdata = wdata_q;
                if (pmem_resp) begin
                    d_resp  = 1'b1;
                    d_rdata = pmem_rdata;
                    state_d = RELEASE;
                end
            end
            RELEASE: state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end
endmodule

// File: tb/tb_pmem_arbiter.sv
// Directed bench for pmem_arbiter; memory side is driven by hand.
module tb_pmem_arbiter;
    localparam int LW = 256;
    localparam int AW = 32;

    logic          clk, rst_n;
    logic          i_read, d_read, d_write, pmem_resp;
    logic [AW-1:0] i_addr, d_addr;
    logic [LW-1:0] d_wdata, pmem_rdata;
    logic [LW-1:0] i_rdata, d_rdata, pmem_wdata;
    logic          i_resp, d_resp, pmem_read, pmem_write;
    logic [AW-1:0] pmem_addr;

    int nvec = 0;
    int nerr = 0;

    pmem_arbiter dut (
        .clk(clk), .rst_n(rst_n),
        .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
        .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_rdata(d_rdata), .d_resp(d_resp),
        .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
        .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [LW-1:0] got, input logic [LW-1:0] exp);
        nvec++;
        if (got !== exp) begin
            nerr++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic chk_quiet(input string tag);
        chk({tag, ".rd"}, LW'(pmem_read), LW'(0));
        chk({tag, ".wr"}, LW'(pmem_write), LW'(0));
        chk({tag, ".iresp"}, LW'(i_resp), LW'(0));
        chk({tag, ".dresp"}, LW'(d_resp), LW'(0));
    endtask

    // Entered at a falling edge where the DUT should already be in a grant state.
    // Returns at the falling edge of the RELEASE cycle.
    task automatic serve(input string tag, input bit is_d, input bit is_wr,
                         input logic [AW-1:0] addr, input logic [LW-1:0] wd,
                         input int lat, input logic [LW-1:0] rd);
        #1;
        chk({tag, ".rd"}, LW'(pmem_read), LW'(!is_wr));
        chk({tag, ".wr"}, LW'(pmem_write), LW'(is_wr));
        chk({tag, ".addr"}, LW'(pmem_addr), LW'(addr));
        if (is_wr) chk({tag, ".wdata"}, pmem_wdata, wd);
        chk({tag, ".early_resp"}, LW'(i_resp | d_resp), LW'(0));
        for (int c = 1; c < lat; c++) begin
            @(negedge clk); #1;
            chk({tag, ".hold_rd"}, LW'(pmem_read), LW'(!is_wr));
            chk({tag, ".hold_addr"}, LW'(pmem_addr), LW'(addr));
            if (is_wr) chk({tag, ".hold_wdata"}, pmem_wdata, wd);
        end
        @(negedge clk);
        pmem_resp  = 1'b1;
        pmem_rdata = rd;
        #1;
        chk({tag, ".iresp"}, LW'(i_resp), LW'(!is_d));
        chk({tag, ".dresp"}, LW'(d_resp), LW'(is_d));
        chk({tag, ".irdata"}, i_rdata, is_d ? LW'(0) : rd);
        chk({tag, ".drdata"}, d_rdata, is_d ? rd : LW'(0));
        @(negedge clk);
        pmem_resp  = 1'b0;
        pmem_rdata = '0;
        #1;
        chk_quiet({tag, ".release"});
        chk({tag, ".release_rdata"}, i_rdata | d_rdata, LW'(0));
    endtask

    initial begin
        logic [LW-1:0] a5, dbf, c3;
        a5  = {32{8'hA5}};
        dbf = {8{32'hDEADBEEF}};
        c3  = {32{8'h3C}};
        rst_n = 1'b0; i_read = 0; d_read = 0; d_write = 0; pmem_resp = 0;
        i_addr = '0; d_addr = '0; d_wdata = '0; pmem_rdata = '0;
        #12;
        chk_quiet("reset");
        chk("reset.addr", LW'(pmem_addr), LW'(0));
        chk("reset.wdata", pmem_wdata, LW'(0));
        @(negedge clk); rst_n = 1'b1;

        // Lone I read with low offset bits set.
        @(negedge clk); i_read = 1; i_addr = 32'h0000_1234;
        @(negedge clk);
        serve("iread", 0, 0, 32'h0000_1220, '0, 3, a5);
        i_read = 0;
        @(negedge clk); #1; chk_quiet("iread.idle");

        // Lone D write; d_wdata changes after grant and must not leak through.
        @(negedge clk); d_write = 1; d_addr = 32'h8000_0040; d_wdata = dbf;
        @(negedge clk); d_wdata = '1;
        serve("dwrite", 1, 1, 32'h8000_0040, dbf, 2, '0);
        d_write = 0;
        @(negedge clk); #1; chk_quiet("dwrite.idle");

        // Reset so last_grant is back at I, then hold both: D,I,D,I.
        rst_n = 0; #1; rst_n = 1;
        @(negedge clk);
        i_read = 1; i_addr = 32'h0000_2000; d_read = 1; d_addr = 32'h0000_3017;
        @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            if (k % 2 == 0) serve($sformatf("rr%0d_d", k), 1, 0, 32'h0000_3000, '0, 1, {8{32'h1000 + k}});
            else            serve($sformatf("rr%0d_i", k), 0, 0, 32'h0000_2000, '0, 1, {8{32'h2000 + k}});
            if (k == 3) begin i_read = 0; d_read = 0; end
            @(negedge clk); #1; chk_quiet($sformatf("rr%0d.idle", k));
            if (k < 3) @(negedge clk);
        end

        // d_read and d_write together behave as a write.
        @(negedge clk); d_read = 1; d_write = 1; d_addr = 32'h0000_0100; d_wdata = c3;
        @(negedge clk);
        serve("drw", 1, 1, 32'h0000_0100, c3, 1, '0);
        d_read = 0; d_write = 0;
        @(negedge clk);

        // Reset in the middle of a D grant.
        @(negedge clk); d_write = 1; d_addr = 32'h0000_4000; d_wdata = dbf;
        @(negedge clk); #1;
        chk("rst_mid.pre_wr", LW'(pmem_write), LW'(1));
        #2; rst_n = 0; d_write = 0; #1;
        chk_quiet("rst_mid");
        chk("rst_mid.addr", LW'(pmem_addr), LW'(0));
        chk("rst_mid.wdata", pmem_wdata, LW'(0));
        @(negedge clk); rst_n = 1;
        @(negedge clk); i_read = 1; i_addr = 32'h0000_0040;
        @(negedge clk);
        serve("post_rst_i", 0, 0, 32'h0000_0040, '0, 2, a5);
        i_read = 0;
        @(negedge clk);

        // I drops its request right after grant; transaction still completes once.
        @(negedge clk); i_read = 1; i_addr = 32'h5555_5555;
        @(negedge clk); i_read = 0;
        serve("idrop", 0, 0, 32'h5555_5540, '0, 3, ~a5);
        @(negedge clk); #1; chk_quiet("idrop.idle1");
        @(negedge clk); #1; chk_quiet("idrop.idle2");

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end
endmodule

// File: doc/pmem_arbiter.md
Name: pmem_arbiter

Overview:
- Sits directly downstream of the instruction cache and data cache, and merges their 256-bit line requests onto the single physical-memory port.
- The instruction side is read-only; the data side reads and writes (write-backs).
- Grants one client at a time, using round-robin on contention.
- Holds the granted address and write data stable for the whole memory transaction.

Parameters:
- LINE_W, 256, cache line / pmem data width in bits
- ADDR_W, 32, byte address width
- OFFSET_W, 5, line-offset bits; forced to zero on pmem_addr

Ports:
- clk  in  1  system clock, rising-edge
- rst_n  in  1  asynchronous, active-low reset
- i_read  in  1  instruction-cache line read request
- i_addr  in  ADDR_W  instruction-cache line address
- i_rdata  out  LINE_W  line data returned to instruction cache
- i_resp  out  1  instruction-cache request complete
- d_read  in  1  data-cache line read request
- d_write  in  1  data-cache line write-back request
- d_addr  in  ADDR_W  data-cache line address
- d_wdata  in  LINE_W  data-cache write-back line
- d_rdata  out  LINE_W  line data returned to data cache
- d_resp  out  1  data-cache request complete
- pmem_read  out  1  physical-memory read strobe
- pmem_write  out  1  physical-memory write strobe
- pmem_addr  out  ADDR_W  line-aligned physical address
- pmem_wdata  out  LINE_W  write-back data to memory
- pmem_rdata  in  LINE_W  read data from memory
- pmem_resp  in  1  memory transaction complete

Behaviour:
- Clock, reset and interface:
  - One clock (clk). Reset rst_n is asynchronous and active-low.
  - All state is reset asynchronously on rst_n low.
- States: IDLE, GRANT_I, GRANT_D, RELEASE.
- Reset values:
  - state=IDLE, last_grant=I (so D wins the first tie).
  - pmem_read=0, pmem_write=0, pmem_addr=0, pmem_wdata=0.
  - i_resp=0, d_resp=0, i_rdata=0, d_rdata=0.
- IDLE:
  - req_i = i_read; req_d = d_read | d_write.
  - Only one request -> grant that client.
  - Both requesting -> grant the client NOT equal to last_grant.
  - On grant, at the same edge:
    - latch the client address with low OFFSET_W bits cleared into addr_q;
    - latch d_wdata into wdata_q;
    - latch op (read/write) into op_q;
    - update last_grant.
  - No request -> stay in IDLE.
- d_read and d_write both high: treat as a write; the read is ignored.
- GRANT_I / GRANT_D:
  - Moore outputs: pmem_addr=addr_q.
  - pmem_read=1 for GRANT_I or a D read; pmem_write=1 for a D write.
  - pmem_wdata=wdata_q.
  - Hold until pmem_resp=1.
- Response cycle (pmem_resp=1 while in GRANT_x):
  - Combinationally, the granted client sees x_resp=1 and x_rdata=pmem_rdata in that same cycle.
  - The other client's resp stays 0.
  - Next state is RELEASE.
- Latency:
  - Grant occurs one cycle after the request is first seen in IDLE.
  - The request completes in the cycle pmem_resp arrives.
  - Minimum total 2 cycles, request to resp.
- RELEASE:
  - One dead cycle with all pmem strobes and resps at 0. This lets the client drop its request, so a stale request is never re-granted.
  - Then IDLE.
- x_rdata outside a resp cycle: drive 0.
- Back-to-back contention: I and D both held high continuously must alternate grants I/D/I/D after the first D. Neither client starves.
- Request dropped by a client while granted: the transaction still completes. resp is still pulsed; the client ignores it.
- Reset mid-transaction:
  - Immediate return to IDLE with all outputs 0.
  - The in-flight memory operation is abandoned; memory is required to tolerate the strobe drop.
- No address decoding or data buffering beyond addr_q/wdata_q; the block never reorders requests.

Decomposition:
- Shared package (arbiter_types_pkg):
  - enum arb_state_t {IDLE, GRANT_I, GRANT_D, RELEASE};
  - enum client_t {CLIENT_I, CLIENT_D};
  - localparams LINE_W and OFFSET_W.
- Optional sub-module rr_arbiter2: a 2-way round-robin pick from req_i, req_d and last_grant, returning the chosen client_t. It is purely combinational, and the FSM owns last_grant.

Test Plan:
- Lone I read, i_addr=0x0000_1234:
  - pmem_read=1 and pmem_addr=0x0000_1220 one cycle later;
  - memory returns resp after 3 cycles with rdata=0xA5..A5;
  - i_resp=1 and i_rdata=0xA5..A5 in that cycle, d_resp=0;
  - RELEASE then IDLE.
- Lone D write, d_addr=0x8000_0040, d_wdata=0xDEAD..BEEF:
  - pmem_write=1, pmem_read=0, pmem_addr=0x8000_0040, pmem_wdata held constant until resp;
  - d_resp pulses once.
- Simultaneous I and D requests out of reset: D granted first. I is held and granted after RELEASE. The grant sequence over 4 transactions with both held is D,I,D,I.
- Both d_read and d_write high, d_addr=0x100: pmem_write=1, pmem_read=0.
- rst_n pulsed low while in GRANT_D before pmem_resp: all outputs go to 0 asynchronously; state returns to IDLE; the next lone I request is granted normally.
- Client drops i_read mid-transaction: pmem_read stays 1 until pmem_resp; i_resp still pulses once; there is no regrant after RELEASE.
